// File: rtl/dt_walker_pkg.sv
// Shared widths, node layout, FSM states and a node-packing helper for the
// table-driven decision-tree walker.
package dt_walker_pkg;

    localparam int IN_W      = 10;
    localparam int OUT_W     = 77;
    localparam int NODES     = 64;
    localparam int MAX_DEPTH = 16;

    localparam int FEAT_W  = $clog2(IN_W);
    localparam int IDX_W   = $clog2(NODES);
    localparam int CLS_W   = $clog2(OUT_W + 1);
    localparam int NODE_W  = 1 + FEAT_W + 2 * IDX_W + CLS_W;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    typedef struct packed {
        logic              isLeaf;
        logic [FEAT_W-1:0] feat;
        logic [IDX_W-1:0]  tChild;
        logic [IDX_W-1:0]  fChild;
        logic [CLS_W-1:0]  cls;
    } node_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } walkState_e;

    function automatic logic [NODE_W-1:0] packNode(input int isLeaf, input int feat,
                                                   input int tChild, input int fChild,
                                                   input int cls);
        node_t n;
        n.isLeaf = (isLeaf != 0);
        n.feat   = FEAT_W'(feat);
        n.tChild = IDX_W'(tChild);
        n.fChild = IDX_W'(fChild);
        n.cls    = CLS_W'(cls);
        return n;
    endfunction

endpackage

// File: rtl/dt_walker_if.sv
// Handshake and configuration bundle between the walker and its feature
// source / class consumer.
interface dt_walker_if;
    import dt_walker_pkg::*;

    logic              cfg_we;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_addr;
    logic [NODE_W-1:0] cfg_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   inp;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  outp;
    logic              err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
        input  cfg_ready, in_ready, out_valid, outp, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
        output cfg_ready, in_ready, out_valid, outp, err
    );

endinterface

// File: rtl/dt_node_table.sv
// Node table: register array cleared by reset, one write port and one
// combinational read port.
module dt_node_table
    import dt_walker_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [NODE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [NODE_W-1:0] rdata_o
);

    logic [NODE_W-1:0] mem_q [NODES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dt_walker.sv
// Sequential decision-tree walker: one node per clock over a captured feature
// vector. Optional counters are built when DT_WALKER_STATS_EN is defined.
module dt_walker
    import dt_walker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    dt_walker_if.slave  bus
`ifdef DT_WALKER_STATS_EN
    ,
    output logic [31:0] stat_done,
    output logic [15:0] stat_err,
    output logic [31:0] stat_steps
`endif
);

    walkState_e         state_q;
    logic [IN_W-1:0]    feat_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [OUT_W-1:0]   outp_q;
    logic               err_q;
    logic               outValid_q;

    logic [NODE_W-1:0]  rdData;
    node_t              node;
    logic               featBit;
    logic [IDX_W-1:0]   ptr_d;
    logic [DEPTH_W-1:0] depth_d;
    logic               childBad;
    logic               depthOver;
    logic [OUT_W-1:0]   leafOut;
    logic               tableWe;

    // The table is only writable while idle, so a walk never sees it change.
    assign tableWe = bus.cfg_we && (state_q == IDLE);

    dt_node_table uTable (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (tableWe),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_wdata),
        .raddr_i (ptr_q),
        .rdata_o (rdData)
    );

    // Decode the current node; out-of-range features read as 0.
    always_comb begin
        node    = node_t'(rdData);
        featBit = 1'b0;
        if (int'(node.feat) < IN_W) begin
            featBit = feat_q[node.feat];
        end
        ptr_d     = featBit ? node.tChild : node.fChild;
        depth_d   = depth_q + DEPTH_W'(1);
        childBad  = int'(ptr_d) >= NODES;
        depthOver = (depth_q == DEPTH_W'(MAX_DEPTH));
        leafOut   = '0;
        if (int'(node.cls) < OUT_W) begin
            leafOut[node.cls] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            feat_q     <= '0;
            ptr_q      <= '0;
            depth_q    <= '0;
            outp_q     <= '0;
            err_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        feat_q  <= bus.inp;
                        ptr_q   <= '0;
                        depth_q <= '0;
                        state_q <= WALK;
                    end
                end
                WALK: begin
                    if (node.isLeaf) begin
                        outp_q     <= leafOut;
                        err_q      <= 1'b0;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (childBad || depthOver) begin
                        outp_q     <= '0;
                        err_q      <= 1'b1;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        ptr_q   <= ptr_d;
                        depth_q <= depth_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.out_valid = outValid_q;
    assign bus.outp      = outp_q;
    assign bus.err       = err_q;

`ifdef DT_WALKER_STATS_EN
    // Saturating activity counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done  <= '0;
            stat_err   <= '0;
            stat_steps <= '0;
        end else begin
            if (state_q == WALK && stat_steps != '1) begin
                stat_steps <= stat_steps + 32'd1;
            end
            if (state_q == DONE && bus.out_ready) begin
                if (stat_done != '1) begin
                    stat_done <= stat_done + 32'd1;
                end
                if (err_q && stat_err != '1) begin
                    stat_err <= stat_err + 16'd1;
                end
            end
        end
    end
`endif

endmodule
